victim_wb_buffer: RTL and testbench
===================================

# victim_wb_buffer

Write-back buffer directly downstream of the victim cache. It captures every valid block the victim cache evicts on a write, together with that block's 50-bit ptag+vindex. It holds the blocks in a FIFO and drains them to the next memory level over a valid/ready handshake. It also offers a registered lookup port, so a victim-cache miss can still be satisfied from a block that has not been written back yet.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- evict_valid  in  1  one-cycle pulse; evict_block/evict_tag hold a valid evicted block this cycle
- evict_block  in  512  evicted data (victim cache block_out)
- evict_tag  in  50  {ptag[43:0], vindex[5:0]} of the evicted block
- evict_full  out  1  buffer cannot accept a push this cycle without a simultaneous pop
- wb_valid  out  1  head entry is presented to the next level
- wb_ready  in  1  next level accepts head when wb_valid && wb_ready
- wb_block  out  512  head entry data
- wb_tag  out  50  head entry tag
- lookup_en  in  1  request a lookup of lookup_tag
- lookup_tag  in  50  ptag+vindex to search
- lookup_hit  out  1  registered lookup result
- lookup_block  out  512  registered data of the matching entry
- count  out  $clog2(DEPTH+1)  occupied entries
- overflow  out  1  sticky; set when a push is dropped

## Operation
- Storage: DEPTH entries, each holding {valid, tag[49:0], block[511:0]}, plus head and tail pointers of width $clog2(DEPTH).
- Pointers wrap from DEPTH-1 to 0.
- Push condition: evict_valid && (count<DEPTH || pop). On push, the entry at tail is written with valid=1, and tail increments.
- Pop condition: wb_valid && wb_ready. On pop, the head entry's valid bit clears, and head increments.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
- Push when full: accepted when a pop occurs in the same cycle; the new entry lands in the slot the pop vacated. Otherwise the push is dropped, the contents are unchanged, and overflow is set to 1. overflow clears only on reset.
- evict_valid is ignored (no push) when count<DEPTH is false and no pop occurs; data on evict_block in that cycle is discarded.
- wb_valid = (count!=0). wb_block and wb_tag are driven combinationally from the entry at head.
- Lookup:
  - Compare lookup_tag against every entry that is valid in the pre-edge state.
  - On lookup_en, register lookup_hit = any match and lookup_block = matching entry data.
  - Multiple matches: the youngest entry, nearest to tail, wins.
  - No match, or lookup_en=0: lookup_hit=0 and lookup_block=0.
- An entry popped in the same cycle as a lookup can still hit, because the lookup sees pre-edge contents.
- An entry pushed in the same cycle is not visible to that lookup.
- evict_full = (count==DEPTH), combinational.
- No internal FSM beyond the FIFO occupancy. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all derived from count.

## Timing
- Reset (asserted low) forces the following:
  - count=0, head=tail=0, all entry valid bits, tags and blocks =0
  - wb_valid=0, wb_block=0, wb_tag=0
  - evict_full=0, lookup_hit=0, lookup_block=0, overflow=0
- Reset mid-operation discards all buffered blocks. The first push after reset release lands in entry 0.
- Push-to-wb_valid latency: 1 cycle. An entry pushed at edge N is presented from edge N.
- Pop takes effect at the edge where wb_valid && wb_ready. The next head is presented in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- Lookup latency: 1 cycle. lookup_en sampled at edge N produces lookup_hit/lookup_block valid after edge N.
- wb_block/wb_tag stay stable while wb_valid=1 and wb_ready=0. The next level may stall indefinitely.

## Test plan
- Reset low mid-stream with 3 entries buffered -> count=0, wb_valid=0, overflow=0, wb_block=0 immediately. After release, push tag 0x5 -> wb_tag=0x5 next cycle.
- Push tags 0x1,0x2,0x3,0x4 (blocks 0xA1..0xA4) with wb_ready=0 -> count=4, evict_full=1. Then wb_ready=1 for 4 cycles -> wb_tag 0x1,0x2,0x3,0x4 in order, count=0.
- With the buffer full and wb_ready=0, push tag 0x9 -> dropped, overflow=1, count stays 4. Then a push of tag 0x9 together with a pop -> accepted, count=4, tail entry tag=0x9.
- Push tag 0x7 twice, with block 0xB1 then 0xB2; lookup_tag=0x7 -> lookup_hit=1, lookup_block=0xB2 one cycle later. Lookup of 0x8 -> lookup_hit=0, lookup_block=0.
- Continuous push+pop for 2*DEPTH+1 cycles with tags 1..9 -> pointer wrap correct, count constant, wb_tag sequence matches push order.
- Lookup of the head tag in the same cycle the head is popped -> lookup_hit=1. Lookup of a tag pushed in the same cycle -> lookup_hit=0.

Source files
------------

// File: rtl/victim_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : victim_wb_buffer_if
// Description : Bundles the eviction push port, the write-back drain port
//               (valid/ready), the lookup port and the buffer status outputs
//               of victim_wb_buffer.
//               master : upstream/downstream side that drives requests
//               slave  : the write-back buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface victim_wb_buffer_if #(
  parameter int DEPTH = 4
);
  // Eviction push from the victim cache
  logic                         evict_valid;
  logic [511:0]                 evict_block;
  logic [49:0]                  evict_tag;
  logic                         evict_full;
  // Write-back drain to the next memory level
  logic                         wb_valid;
  logic                         wb_ready;
  logic [511:0]                 wb_block;
  logic [49:0]                  wb_tag;
  // Lookup port for victim-cache misses
  logic                         lookup_en;
  logic [49:0]                  lookup_tag;
  logic                         lookup_hit;
  logic [511:0]                 lookup_block;
  // Status
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport slave (
    input  evict_valid, evict_block, evict_tag, wb_ready, lookup_en, lookup_tag,
    output evict_full, wb_valid, wb_block, wb_tag, lookup_hit, lookup_block,
           count, overflow
  );

  modport master (
    output evict_valid, evict_block, evict_tag, wb_ready, lookup_en, lookup_tag,
    input  evict_full, wb_valid, wb_block, wb_tag, lookup_hit, lookup_block,
           count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/victim_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : victim_wb_buffer
// Description : FIFO write-back buffer behind the victim cache. Captures
//               evicted blocks with their {ptag,vindex}, drains them over a
//               valid/ready handshake, and offers a registered lookup so a
//               victim-cache miss can be served from a not-yet-written block.
// Ports       : clk   - clock, all state updates on posedge
//               rst_n - asynchronous active-low reset
//               bus   - victim_wb_buffer_if.slave (push, drain, lookup, status)
// Revision    : 1.0 - initial release
// ============================================================================
module victim_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  victim_wb_buffer_if.slave    bus
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W   = $clog2(DEPTH+1);
  localparam int c_TAG_W   = 50;
  localparam int c_BLOCK_W = 512;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  logic                 r_valid [DEPTH];
  logic [c_TAG_W-1:0]   r_tag   [DEPTH];
  logic [c_BLOCK_W-1:0] r_block [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_lookup_hit;
  logic [c_BLOCK_W-1:0] r_lookup_block;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_hit;
  logic [c_BLOCK_W-1:0] w_hit_block;

  assign w_pop  = (r_count != '0) && bus.wb_ready;
  assign w_push = bus.evict_valid && ((r_count < c_FULL_CNT) || w_pop);

  // Scan from head (oldest) toward tail (youngest); a later match overrides
  // an earlier one so the youngest duplicate wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_block = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[r_head + c_PTR_W'(i)] &&
          (r_tag[r_head + c_PTR_W'(i)] == bus.lookup_tag)) begin
        w_hit       = 1'b1;
        w_hit_block = r_block[r_head + c_PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_block[i] <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_lookup_hit   <= 1'b0;
      r_lookup_block <= '0;
    end else begin
      // Pop is applied before push: when full, head==tail and the pushed
      // entry must take over the slot the pop just vacated.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tag[r_tail]   <= bus.evict_tag;
        r_block[r_tail] <= bus.evict_block;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (bus.evict_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
      // Lookup sees pre-edge contents: same-cycle pops still hit,
      // same-cycle pushes are not yet visible.
      if (bus.lookup_en) begin
        r_lookup_hit   <= w_hit;
        r_lookup_block <= w_hit_block;
      end else begin
        r_lookup_hit   <= 1'b0;
        r_lookup_block <= '0;
      end
    end
  end

  assign bus.evict_full   = (r_count == c_FULL_CNT);
  assign bus.wb_valid     = (r_count != '0);
  assign bus.wb_block     = r_block[r_head];
  assign bus.wb_tag       = r_tag[r_head];
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.lookup_hit   = r_lookup_hit;
  assign bus.lookup_block = r_lookup_block;

endmodule
`default_nettype wire

// File: tb/tb_victim_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_victim_wb_buffer
// Description : Self-checking bench for victim_wb_buffer (DEPTH=4): table of
//               per-cycle vectors with hand-computed expectations, plus a
//               hand-written asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_victim_wb_buffer;

  localparam int c_DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  victim_wb_buffer_if #(.DEPTH(c_DEPTH)) vif ();

  victim_wb_buffer #(.DEPTH(c_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [49:0] tag;
    logic [31:0] blk;
    logic        rdy;
    logic        len;
    logic [49:0] ltag;
    logic [2:0]  cnt;
    logic        wbv;
    logic [49:0] wtag;
    logic [31:0] wblk;
    logic        full;
    logic        hit;
    logic [31:0] lblk;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ev, input logic [49:0] tag, input logic [31:0] blk,
                     input logic rdy, input logic len, input logic [49:0] ltag,
                     input logic [2:0] cnt, input logic wbv, input logic [49:0] wtag,
                     input logic [31:0] wblk, input logic full, input logic hit,
                     input logic [31:0] lblk, input logic ovf);
    vec_t v;
    v.ev = ev; v.tag = tag; v.blk = blk; v.rdy = rdy; v.len = len; v.ltag = ltag;
    v.cnt = cnt; v.wbv = wbv; v.wtag = wtag; v.wblk = wblk; v.full = full;
    v.hit = hit; v.lblk = lblk; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ev, input logic [49:0] tag, input logic [31:0] blk,
                       input logic rdy, input logic len, input logic [49:0] ltag);
    vif.evict_valid = ev;
    vif.evict_tag   = tag;
    vif.evict_block = {480'd0, blk};
    vif.wb_ready    = rdy;
    vif.lookup_en   = len;
    vif.lookup_tag  = ltag;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);

    //   ev tag   blk      rdy len ltag  cnt wbv wtag  wblk     full hit lblk     ovf
    add(1, 50'h1, 32'hA1, 0, 0, 50'h0, 1, 1, 50'h1, 32'hA1, 0, 0, 32'h0, 0);
    add(1, 50'h2, 32'hA2, 0, 0, 50'h0, 2, 1, 50'h1, 32'hA1, 0, 0, 32'h0, 0);
    add(1, 50'h3, 32'hA3, 0, 0, 50'h0, 3, 1, 50'h1, 32'hA1, 0, 0, 32'h0, 0);
    add(1, 50'h4, 32'hA4, 0, 0, 50'h0, 4, 1, 50'h1, 32'hA1, 1, 0, 32'h0, 0);
    // full, no pop: push of 0x9 dropped
    add(1, 50'h9, 32'hFF, 0, 0, 50'h0, 4, 1, 50'h1, 32'hA1, 1, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  0, 1, 50'h9, 4, 1, 50'h1, 32'hA1, 1, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  0, 1, 50'h3, 4, 1, 50'h1, 32'hA1, 1, 1, 32'hA3, 1);
    // full, push with pop; lookup of popped head still hits
    add(1, 50'h9, 32'hC9, 1, 1, 50'h1, 4, 1, 50'h2, 32'hA2, 1, 1, 32'hA1, 1);
    add(0, 50'h0, 32'h0,  1, 1, 50'h9, 3, 1, 50'h3, 32'hA3, 0, 1, 32'hC9, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 2, 1, 50'h4, 32'hA4, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 1, 1, 50'h9, 32'hC9, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 0, 0, 50'h0, 32'h0,  0, 0, 32'h0, 1);
    // duplicate tags: youngest wins
    add(1, 50'h7, 32'hB1, 0, 0, 50'h0, 1, 1, 50'h7, 32'hB1, 0, 0, 32'h0, 1);
    add(1, 50'h7, 32'hB2, 0, 0, 50'h0, 2, 1, 50'h7, 32'hB1, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  0, 1, 50'h7, 2, 1, 50'h7, 32'hB1, 0, 1, 32'hB2, 1);
    add(0, 50'h0, 32'h0,  0, 1, 50'h8, 2, 1, 50'h7, 32'hB1, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  0, 0, 50'h7, 2, 1, 50'h7, 32'hB1, 0, 0, 32'h0, 1);
    // same-cycle push is invisible to the lookup, visible next cycle
    add(1, 50'h5, 32'hD5, 0, 1, 50'h5, 3, 1, 50'h7, 32'hB1, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  0, 1, 50'h5, 3, 1, 50'h7, 32'hB1, 0, 1, 32'hD5, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 2, 1, 50'h7, 32'hB2, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 1, 1, 50'h5, 32'hD5, 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 0, 0, 50'h0, 32'h0,  0, 0, 32'h0, 1);
    // sustained push+pop across pointer wrap
    add(1, 50'h0, 32'h100, 0, 0, 50'h0, 1, 1, 50'h0, 32'h100, 0, 0, 32'h0, 1);
    for (int i = 1; i <= 2*c_DEPTH+1; i++)
      add(1, 50'(i), 32'h100 + 32'(i), 1, 0, 50'h0, 1, 1, 50'(i), 32'h100 + 32'(i), 0, 0, 32'h0, 1);
    add(0, 50'h0, 32'h0,  1, 0, 50'h0, 0, 0, 50'h0, 32'h0,  0, 0, 32'h0, 1);

    // reset state
    @(posedge clk);
    #1;
    chk("rst_count", 512'(vif.count), 512'd0);
    chk("rst_wb_valid", 512'(vif.wb_valid), 512'd0);
    chk("rst_wb_block", vif.wb_block, 512'd0);
    chk("rst_wb_tag", 512'(vif.wb_tag), 512'd0);
    chk("rst_evict_full", 512'(vif.evict_full), 512'd0);
    chk("rst_overflow", 512'(vif.overflow), 512'd0);
    chk("rst_lookup_hit", 512'(vif.lookup_hit), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ev, vecs[k].tag, vecs[k].blk, vecs[k].rdy, vecs[k].len, vecs[k].ltag);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", k), 512'(vif.count), 512'(vecs[k].cnt));
      chk($sformatf("v%0d_wb_valid", k), 512'(vif.wb_valid), 512'(vecs[k].wbv));
      if (vecs[k].wbv) begin
        chk($sformatf("v%0d_wb_tag", k), 512'(vif.wb_tag), 512'(vecs[k].wtag));
        chk($sformatf("v%0d_wb_block", k), vif.wb_block, 512'(vecs[k].wblk));
      end
      chk($sformatf("v%0d_evict_full", k), 512'(vif.evict_full), 512'(vecs[k].full));
      chk($sformatf("v%0d_lookup_hit", k), 512'(vif.lookup_hit), 512'(vecs[k].hit));
      chk($sformatf("v%0d_lookup_block", k), vif.lookup_block, 512'(vecs[k].lblk));
      chk($sformatf("v%0d_overflow", k), 512'(vif.overflow), 512'(vecs[k].ovf));
    end

    // mid-stream asynchronous reset with 3 entries buffered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 50'h11 + 50'(i), 32'hE0 + 32'(i), 1'b0, 1'b0, '0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("pre_reset_count", 512'(vif.count), 512'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 512'(vif.count), 512'd0);
    chk("async_rst_wb_valid", 512'(vif.wb_valid), 512'd0);
    chk("async_rst_overflow", 512'(vif.overflow), 512'd0);
    chk("async_rst_wb_block", vif.wb_block, 512'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 50'h5, 32'h55, 1'b0, 1'b1, 50'h11);
    @(posedge clk);
    #1;
    chk("post_rst_wb_tag", 512'(vif.wb_tag), 512'h5);
    chk("post_rst_wb_block", vif.wb_block, 512'h55);
    chk("post_rst_count", 512'(vif.count), 512'd1);
    chk("post_rst_old_lookup", 512'(vif.lookup_hit), 512'd0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
